// File: rtl/simon_sequencer.sv
// ---------------------------------------------------------------------------
// simon_sequencer
// Memory game sequencer. Each round one random color (from a free-running
// 16-bit LFSR) is appended to the sequence. The whole sequence is played back
// as lit/dark intervals, then the player must repeat it on the push buttons.
// Reaching the target length wins; a wrong key, a multi-key press or an idle
// timeout loses.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   resetn    in   synchronous active-low reset
//   start     in   level request for a new game (IDLE/WIN/LOSE only)
//   level     in   difficulty 1..5, target length = 4*level
//   KEY[3:0]  in   raw active-low buttons, asynchronous
//   state     out  phase code 00 ready, 01 playback, 10 user, 11 over
//   color     out  one-hot active-high display, bit i <-> KEY[i]
//   round     out  current sequence length
//   win/lose  out  high while in WIN / LOSE
// ---------------------------------------------------------------------------
module simon_sequencer #(
  parameter int unsigned TONE_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES   = 12500000,
  parameter int unsigned USER_TIMEOUT = 150000000,
  parameter int unsigned MAX_LEN      = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [3:0] KEY,
  output logic [1:0] state,
  output logic [3:0] color,
  output logic [4:0] round,
  output logic       win,
  output logic       lose
);

  localparam logic [31:0] TONE_LAST = 32'(TONE_CYCLES - 32'd1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 32'd1);
  localparam logic [31:0] TO_LAST   = 32'(USER_TIMEOUT - 32'd1);
  localparam logic [4:0]  MAX_LEN_L = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_PLAY_ON  = 3'd2,
    S_PLAY_GAP = 3'd3,
    S_USER     = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_e;

  function automatic logic [3:0] onehot(input logic [1:0] sym);
    return 4'b0001 << sym;
  endfunction

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [1:0] phase_code(input state_e s);
    case (s)
      S_IDLE:                        return 2'b00;
      S_GEN, S_PLAY_ON, S_PLAY_GAP:  return 2'b01;
      S_USER:                        return 2'b10;
      S_WIN, S_LOSE:                 return 2'b11;
      default:                       return 2'b00;
    endcase
  endfunction

  // Out-of-range difficulty falls back to the easiest game (length 4).
  function automatic logic [4:0] target_of(input logic [2:0] lv);
    logic [4:0] t;
    if ((lv >= 3'd1) && (lv <= 3'd5)) t = {lv, 2'b00};
    else                              t = 5'd4;
    if (t > MAX_LEN_L) t = MAX_LEN_L;
    else               t = t;
    return t;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  len_q, len_d, idx_q, idx_d, target_q, target_d;
  logic [31:0] cnt_q, cnt_d, to_q, to_d;
  logic [15:0] lfsr_q;
  logic [3:0]  key_s1_q, key_s2_q, key_prev_q;
  logic [3:0]  color_q, color_d;
  logic [1:0]  code_q;
  logic [4:0]  round_q;
  logic        win_q, lose_q;
  logic [1:0]  mem_q [MAX_LEN];
  logic        mem_we_s;
  logic [3:0]  fall_s;
  logic        press_s, single_s, last_s;
  logic [1:0]  exp_sym_s, play_sym_s;

  // A press event is any synchronized key going 1->0 this cycle.
  assign fall_s    = key_prev_q & ~key_s2_q;
  assign press_s   = |fall_s;
  assign single_s  = ((fall_s & (fall_s - 4'd1)) == 4'd0);
  assign last_s    = (idx_q == (len_q - 5'd1));
  assign exp_sym_s = (idx_q < MAX_LEN_L) ? mem_q[idx_q] : 2'b00;

  // Key synchronizer, edge-detect history and free-running LFSR.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      key_s1_q   <= 4'b1111;
      key_s2_q   <= 4'b1111;
      key_prev_q <= 4'b1111;
      lfsr_q     <= 16'hACE1;
    end else begin
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      lfsr_q     <= lfsr_step(lfsr_q);
    end
  end

  // Next-state and datapath decisions for the game FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    target_d = target_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          target_d = target_of(level);
          len_d    = 5'd0;
          idx_d    = 5'd0;
          cnt_d    = 32'd0;
          state_d  = S_GEN;
        end else begin
          state_d = state_q;
        end
      end
      S_GEN: begin
        if (len_q < MAX_LEN_L) begin
          mem_we_s = 1'b1;
          len_d    = len_q + 5'd1;
        end else begin
          len_d = len_q;
        end
        idx_d   = 5'd0;
        cnt_d   = 32'd0;
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (cnt_q >= TONE_LAST) begin
          cnt_d   = 32'd0;
          state_d = S_PLAY_GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PLAY_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d = 32'd0;
          if (last_s) begin
            idx_d   = 5'd0;
            to_d    = 32'd0;
            state_d = S_USER;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_PLAY_ON;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_USER: begin
        // A press in the timeout cycle wins over the timeout.
        if (press_s) begin
          to_d = 32'd0;
          if (single_s && (fall_s == onehot(exp_sym_s))) begin
            if (last_s) begin
              if (len_q >= target_q) state_d = S_WIN;
              else                   state_d = S_GEN;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (to_q >= TO_LAST) begin
          state_d = S_LOSE;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next state; the symbol written in GEN is forwarded
  // so the first tone of round 1 does not read the memory before its write.
  always_comb begin
    if (mem_we_s && (idx_d == len_q)) begin
      play_sym_s = lfsr_q[1:0];
    end else if (idx_d < MAX_LEN_L) begin
      play_sym_s = mem_q[idx_d];
    end else begin
      play_sym_s = 2'b00;
    end
    case (state_d)
      S_PLAY_ON: color_d = onehot(play_sym_s);
      S_USER:    color_d = ~key_s1_q;
      S_WIN:     color_d = 4'b1111;
      default:   color_d = 4'b0000;
    endcase
  end

  // Game FSM state, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      len_q    <= 5'd0;
      idx_q    <= 5'd0;
      cnt_q    <= 32'd0;
      to_q     <= 32'd0;
      target_q <= 5'd0;
      color_q  <= 4'b0000;
      code_q   <= 2'b00;
      round_q  <= 5'd0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      target_q <= target_d;
      color_q  <= color_d;
      code_q   <= phase_code(state_d);
      round_q  <= len_d;
      win_q    <= (state_d == S_WIN);
      lose_q   <= (state_d == S_LOSE);
    end
  end

  // Sequence store; contents are meaningless until written in GEN.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we_s) begin
      mem_q[len_q] <= lfsr_q[1:0];
    end else begin
      mem_q[len_q] <= mem_q[len_q];
    end
  end

  assign state = code_q;
  assign color = color_q;
  assign round = round_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 TONE_CYCLES, default 25000000, number of clocks each sequence color is lit during playback.
REQ-002 GAP_CYCLES, default 12500000, number of dark clocks after each lit color.
REQ-003 USER_TIMEOUT, default 150000000, number of idle clocks allowed between user presses.
REQ-004 MAX_LEN, default 20, depth of the sequence store in 2-bit entries.
REQ-005 CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  level-sensitive request to begin a new game.
REQ-008 level  input  3  difficulty, valid values 1..5.
REQ-009 KEY  input  4  raw push buttons, active-low, asynchronous.
REQ-010 state  output  2  phase code: 00 ready, 01 game (playback), 10 user, 11 over.
REQ-011 color  output  4  one-hot active-high color to display; bit i corresponds to KEY[i].
REQ-012 round  output  5  current sequence length.
REQ-013 win  output  1  high while in the WIN state.
REQ-014 lose  output  1  high while in the LOSE state.

Function
REQ-015 The LFSR SHALL be 16 bits, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, and SHALL step every clock in all states; the color index is lfsr[1:0].
REQ-016 KEY SHALL pass through a 2-flop synchronizer; a press event is one cycle of any synchronized bit going 1->0; events outside USER_WAIT SHALL be discarded, not queued.
REQ-017 States: IDLE, GEN, PLAY_ON, PLAY_GAP, USER_WAIT, WIN, LOSE; state code IDLE=00, GEN/PLAY_ON/PLAY_GAP=01, USER_WAIT=10, WIN/LOSE=11.
REQ-018 IDLE/WIN/LOSE with start=1: latch target=4*level (level 0 or >5 gives target 4), set len=0, go to GEN; start is ignored in every other state.
REQ-019 GEN (1 cycle): mem[len]<=lfsr[1:0], len<=len+1, idx<=0, go to PLAY_ON.
REQ-020 PLAY_ON: color=onehot(mem[idx]) for exactly TONE_CYCLES cycles, then go to PLAY_GAP.
REQ-021 PLAY_GAP: color=0 for exactly GAP_CYCLES cycles; then, if idx==len-1, set idx<=0, clear the timeout counter, and go to USER_WAIT; otherwise idx<=idx+1 and go to PLAY_ON.
REQ-022 USER_WAIT: color = synchronized ~KEY (echo of held keys); the timeout counter increments each cycle and clears on each press event.
REQ-023 Press event with exactly one bit falling, equal to onehot(mem[idx]): if idx==len-1 and len==target, go to WIN; if idx==len-1 and len<target, go to GEN; otherwise idx<=idx+1.
REQ-024 A press event with a wrong bit, or with two or more bits falling in the same cycle, SHALL go to LOSE.
REQ-025 Timeout counter reaching USER_TIMEOUT SHALL go to LOSE; a press event in the same cycle takes priority over the timeout.
REQ-026 WIN: color=4'b1111, win=1; LOSE: color=4'b0000, lose=1; both states hold until start or reset.
REQ-027 round SHALL equal len at all times; len SHALL never exceed MAX_LEN; target is clamped to MAX_LEN.

Reset
REQ-028 resetn=0 at a clock edge, including mid-game, SHALL take effect at that edge and give:
- state IDLE
- color=0, round=0, win=0, lose=0
- lfsr=16'hACE1
- synchronizer flops=4'b1111
- all counters=0
REQ-029 Sequence memory contents SHALL be don't-care after reset.

Verification
Parameter overrides: TONE_CYCLES=4, GAP_CYCLES=2, USER_TIMEOUT=50.
REQ-030 Reset, then start=1 with level=1 -> GEN one cycle later; state=01; round=1; color one-hot for 4 cycles, then 0 for 2 cycles; then state=10.
REQ-031 Each round, press the played colors in order -> round increments 1,2,3,4; after the 4th correct press of round 4, state=11, win=1, color=1111.
REQ-032 In USER_WAIT, press a wrong key -> lose=1, state=11, color=0000 within 3 cycles of the KEY edge; later start=1 -> round=1, lose=0.
REQ-033 Hold no key in USER_WAIT for 50 cycles -> lose=1; a press at cycle 49 -> no lose, and the counter restarts.
REQ-034 Press KEY[0] and KEY[2] in the same cycle -> lose=1; press any key during PLAY_ON -> ignored, with no effect on idx.
REQ-035 Assert resetn=0 during PLAY_ON in round 3 -> on the next edge state=00, round=0, color=0; start with level=7 -> target=4.
